// File: rtl/iob_native_mem_responder_pkg.sv
// Shared definitions for the native memory responder: FSM encoding, latency counter
// width and the stall LFSR step.
package iob_native_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // 4 bits of configured latency plus 2 bits of injected stall
  localparam int CNT_W = 6;

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/iob_sp_ram_be.sv
// Single-port byte-enable RAM with synchronous read (read-before-write on the port).
module iob_sp_ram_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     d,
  output logic [DATA_W-1:0]     q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= d[i*8 +: 8];
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/iob_native_mem_responder.sv
// Responder end of the native memory interface: latency/stall FSM in front of a
// byte-enable RAM.
module iob_native_mem_responder
  import iob_native_mem_responder_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter int         MEM_ADDR_W = 10,
  parameter int         RD_LAT     = 2,
  parameter int         WR_LAT     = 1,
  parameter int         STALL_EN   = 0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = $clog2(NBYTES);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt, start_cnt, lat_m1;
  logic [7:0]            lfsr;
  logic [1:0]            extra;
  logic                  is_wr_in, wr_q, accept, rd_issue, read_sel;
  logic [MEM_ADDR_W-1:0] req_idx, idx_q, ram_addr;
  logic [DATA_W-1:0]     wdata_q, ram_q, rdata_q;
  logic [NBYTES-1:0]     wstrb_q, ram_we;
  logic                  addr_unused;

  assign req_idx     = mem_addr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
  assign addr_unused = ^mem_addr;
  assign is_wr_in    = |mem_wstrb;
  assign accept      = (state == IDLE) && mem_valid;
  assign extra       = (STALL_EN != 0) ? lfsr[1:0] : 2'd0;
  assign lat_m1      = is_wr_in ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
  assign start_cnt   = lat_m1 + {{(CNT_W-2){1'b0}}, extra};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          cnt_nxt   = start_cnt;
          state_nxt = (start_cnt == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the request is still on the bus; afterwards only the latched copy counts
  assign read_sel = (state == IDLE) ? !is_wr_in : !wr_q;
  assign rd_issue = (state_nxt == RESP) && (state != RESP) && read_sel;
  assign ram_addr = (state == IDLE) ? req_idx : idx_q;
  assign ram_we   = (state == RESP && wr_q) ? wstrb_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lfsr <= lfsr_next(lfsr);
        wr_q <= is_wr_in;
      end
      if (state == RESP && !wr_q) rdata_q <= ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= req_idx;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
    end
  end

  iob_sp_ram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (rd_issue || (|ram_we)),
    .we   (ram_we),
    .addr (ram_addr),
    .d    (wdata_q),
    .q    (ram_q)
  );

  assign mem_ready = (state == RESP);
  assign busy      = (state != IDLE);
  assign mem_rdata = (state == RESP && !wr_q) ? ram_q : rdata_q;

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Directed bench for iob_native_mem_responder: three instances cover the default
// latencies, single-cycle back-to-back, and stall injection.
module tb_iob_native_mem_responder;

  logic        clk = 1'b0;
  logic        reset [3];
  logic        valid [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic [31:0] last_rd [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_native_mem_responder #(.RD_LAT(2), .WR_LAT(1), .STALL_EN(0)) dut0 (
    .clk(clk), .reset(reset[0]), .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
    .mem_ready(ready[0]), .busy(busy[0]));

  iob_native_mem_responder #(.RD_LAT(1), .WR_LAT(1), .STALL_EN(0)) dut1 (
    .clk(clk), .reset(reset[1]), .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
    .mem_ready(ready[1]), .busy(busy[1]));

  iob_native_mem_responder #(.RD_LAT(2), .WR_LAT(3), .STALL_EN(1), .LFSR_SEED(8'hA5)) dut2 (
    .clk(clk), .reset(reset[2]), .mem_valid(valid[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_rdata(rdata[2]),
    .mem_ready(ready[2]), .busy(busy[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends RESP.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int lat);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    lat = 0; rd = '0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready[d] && lat < 40);
    if (!ready[d]) chk("ready_timeout", {31'b0, ready[d]}, 32'd1);
    rd = rdata[d];
    valid[d] = 1'b0; wstrb[d] = '0;
    @(posedge clk); #1;
    if (ws == 4'h0) last_rd[d] = rd;
    chk("rdata_hold", rdata[d], last_rd[d]);
    chk("busy_idle", {31'b0, busy[d]}, 32'd0);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vt [16];
    logic [31:0] rd, m [16], b2b_exp [4];
    int          lat, n;
    bit          saw_extra;

    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b0; valid[i] = 1'b1; addr[i] = 32'h200;
      wdata[i] = 32'h55AA55AA; wstrb[i] = 4'hF; last_rd[i] = '0;
    end

    vt[0]  = '{0, 32'h40,       32'hDEADBEEF, 4'hF,    32'h0,        1};
    vt[1]  = '{0, 32'h40,       32'h0,        4'h0,    32'hDEADBEEF, 2};
    vt[2]  = '{0, 32'h8,        32'h11223344, 4'hF,    32'h0,        1};
    vt[3]  = '{0, 32'h8,        32'hAABBCCDD, 4'b0101, 32'h0,        1};
    vt[4]  = '{0, 32'h8,        32'h0,        4'h0,    32'h11BB33DD, 2};
    vt[5]  = '{0, 32'h1000,     32'hCAFE0001, 4'hF,    32'h0,        1};
    vt[6]  = '{0, 32'h0,        32'h0,        4'h0,    32'hCAFE0001, 2};
    vt[7]  = '{0, 32'hFFFFF003, 32'h0,        4'h0,    32'hCAFE0001, 2};
    vt[8]  = '{0, 32'hC,        32'h12345678, 4'hF,    32'h0,        1};
    vt[9]  = '{0, 32'hF,        32'hA0B0C0D0, 4'b1010, 32'h0,        1};
    vt[10] = '{0, 32'hC,        32'h0,        4'h0,    32'hA034C078, 2};
    vt[11] = '{1, 32'h0,        32'h11110000, 4'hF,    32'h0,        1};
    vt[12] = '{1, 32'h4,        32'h22220001, 4'hF,    32'h0,        1};
    vt[13] = '{1, 32'h8,        32'h33330002, 4'hF,    32'h0,        1};
    vt[14] = '{1, 32'hC,        32'h44440003, 4'hF,    32'h0,        1};
    vt[15] = '{1, 32'h4,        32'h0,        4'h0,    32'h22220001, 1};
    b2b_exp = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};

    // Reset held with valid asserted: nothing may start
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk("rst_ready", {31'b0, ready[i]}, 32'd0);
        chk("rst_busy",  {31'b0, busy[i]},  32'd0);
        chk("rst_rdata", rdata[i], 32'd0);
      end
    end
    valid[1] = 1'b0; valid[2] = 1'b0; wstrb[1] = '0; wstrb[2] = '0;
    for (int i = 0; i < 3; i++) reset[i] = 1'b1;
    @(posedge clk); #1;
    chk("first_accept_ready", {31'b0, ready[0]}, 32'd1);
    chk("first_accept_busy",  {31'b0, busy[0]},  32'd1);
    valid[0] = 1'b0; wstrb[0] = '0;
    @(posedge clk); #1;

    for (int v = 0; v < 16; v++) begin
      do_req(vt[v].d, vt[v].a, vt[v].wd, vt[v].ws, rd, lat);
      chk($sformatf("vec%0d_lat", v), lat, vt[v].lat);
      if (vt[v].ws == 4'h0) chk($sformatf("vec%0d_rdata", v), rd, vt[v].exp);
    end

    // Back-to-back reads with valid held high on the single-cycle instance
    valid[1] = 1'b1; addr[1] = 32'h0; wstrb[1] = '0;
    n = 0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ready_c%0d", j), {31'b0, ready[1]}, {31'b0, (j % 2) == 1});
      if (ready[1] && n < 4) begin
        chk($sformatf("b2b_data%0d", n), rdata[1], b2b_exp[n]);
        n++;
        if (n < 4) addr[1] = 32'(n * 4);
        else valid[1] = 1'b0;
      end
    end
    chk("b2b_count", n, 4);
    chk("b2b_busy_end", {31'b0, busy[1]}, 32'd0);

    // Stall injection against a word model
    saw_extra = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m[i] = $urandom;
      do_req(2, ($urandom & 32'hFFFF_F000) | 32'(i << 2), m[i], 4'hF, rd, lat);
      chk("stall_init_lat", {31'b0, lat >= 3 && lat <= 6}, 32'd1);
      if (lat > 3) saw_extra = 1'b1;
    end
    for (int op = 0; op < 200; op++) begin
      int          idx;
      logic [31:0] a, wd;
      logic [3:0]  ws;
      idx = $urandom_range(0, 15);
      a   = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        ws = 4'($urandom_range(1, 15));
        do_req(2, a, wd, ws, rd, lat);
        for (int b = 0; b < 4; b++) if (ws[b]) m[idx][b*8 +: 8] = wd[b*8 +: 8];
        chk("stall_wr_lat", {31'b0, lat >= 3 && lat <= 6}, 32'd1);
        if (lat > 3) saw_extra = 1'b1;
      end else begin
        do_req(2, a, 32'h0, 4'h0, rd, lat);
        chk($sformatf("stall_rd_data_op%0d", op), rd, m[idx]);
        chk("stall_rd_lat", {31'b0, lat >= 2 && lat <= 5}, 32'd1);
        if (lat > 2) saw_extra = 1'b1;
      end
    end
    chk("stall_seen", {31'b0, saw_extra}, 32'd1);

    // Reset while a write waits: the word must keep its old value
    valid[2] = 1'b1; addr[2] = 32'h14; wdata[2] = ~m[5]; wstrb[2] = 4'hF;
    @(posedge clk); #1;
    chk("midwait_busy",  {31'b0, busy[2]},  32'd1);
    chk("midwait_ready", {31'b0, ready[2]}, 32'd0);
    reset[2] = 1'b0;
    #2;
    chk("midwait_rst_busy", {31'b0, busy[2]}, 32'd0);
    valid[2] = 1'b0; wstrb[2] = '0;
    @(posedge clk); #1;
    reset[2] = 1'b1;
    last_rd[2] = '0;
    @(posedge clk); #1;
    chk("midwait_rdata_rst", rdata[2], 32'd0);
    do_req(2, 32'h14, 32'h0, 4'h0, rd, lat);
    chk("midwait_word_kept", rd, m[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
